hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage combi (RISC-V/ARM) pipeline.
- Drives the execute-stage forwarding selects and the per-stage stall/flush controls.
- Detects load-use hazards and branch/PC redirects.
- Runs a wait-state FSM that freezes the pipeline while a data-memory access in M is not ready, with a timeout and a halt-on-error state.

Parameters:
TIMEOUT, 16, max consecutive wait cycles before error (1..255)
CNTW, 16, width of saturating stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
Rs1D  in  5  source reg 1 of instruction in D
Rs2D  in  5  source reg 2 of instruction in D
Rs1E  in  5  source reg 1 of instruction in E
Rs2E  in  5  source reg 2 of instruction in E
RdE  in  5  destination reg in E
RdM  in  5  destination reg in M
RdW  in  5  destination reg in W
RegWriteM  in  1  M writes the register file
RegWriteW  in  1  W writes the register file
ResultSrcE0  in  1  instruction in E is a load (ResultSrcE bit 0)
armE  in  1  instruction in E is ARM (1) or RISC-V (0)
RedirectE  in  1  PC redirect from E (RVPCSrcE | BranchTakenE | PCSrcE)
MemAccessM  in  1  load/store present in M
MemReadyM  in  1  data memory completes the access this cycle
ForwardAE  out  2  operand A select: 00 Rd1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushW  out  1  clear M/W register (insert bubble)
MemErr  out  1  sticky timeout error, pipeline halted
StallCnt  out  CNTW  saturating count of cycles with StallF=1

Behaviour:
- Forwarding (combinational, evaluated for each operand X in {A,B}, Rs=Rs1E/Rs2E):
  - 10 if RegWriteM && RdM==Rs && (armE || Rs!=0).
  - else 01 if RegWriteW && RdW==Rs && (armE || Rs!=0).
  - else 00.
  - M has priority over W. ARM R0 is forwarded; RISC-V x0 never is.
- Load-use (combinational): lduse = ResultSrcE0 && (RdE==Rs1D || RdE==Rs2D) && (armE || RdE!=0).
- FSM states RUN, WAIT, HALT. Reset -> RUN; wait counter wcnt=0.
- memwait = MemAccessM && !MemReadyM.
- RUN:
  - memwait -> WAIT next cycle; freeze applies in the same cycle (combinational from memwait).
  - no memwait:
    - StallF = StallD = lduse.
    - FlushE = lduse | RedirectE.
    - FlushD = RedirectE.
    - StallE = StallM = FlushW = 0.
- Freeze, asserted in WAIT and in RUN when memwait:
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0: the redirect is deferred.
  - Because E is held, RedirectE stays asserted and its flush takes effect on the first non-frozen cycle.
- WAIT:
  - wcnt increments each cycle.
  - MemReadyM=1 -> RUN, wcnt=0. Outputs that cycle are RUN outputs (unfrozen).
  - wcnt reaches TIMEOUT-1 with MemReadyM=0 -> HALT, MemErr=1.
  - MemReadyM=1 and timeout in the same cycle: ready wins, go to RUN.
  - MemAccessM dropping to 0 in WAIT -> RUN, wcnt=0.
- HALT:
  - Freeze outputs held permanently; MemErr=1; inputs ignored.
  - Exit only via rst.
- StallCnt increments every cycle StallF=1 and saturates at all-ones.
- Reset (async, any state, including mid-WAIT):
  - state=RUN, wcnt=0, MemErr=0, StallCnt=0.
  - All stall/flush outputs follow the RUN equations with current inputs; nominally 0.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, armE=0 -> ForwardAE=10. Then Rs1E=0 with RdM=RdW=0 -> 00 (RISC-V); armE=1 -> 10.
- Load in E: ResultSrcE0=1, RdE=3, Rs2D=3 -> one cycle of StallF=StallD=FlushE=1. Next cycle (ResultSrcE0=0) -> all 0. StallCnt goes 0->1.
- RedirectE=1, no memwait -> FlushD=FlushE=1, StallF=0. Same cycle with lduse=1 -> FlushE=1, StallF=1.
- MemAccessM=1, MemReadyM=0 for 3 cycles then 1 -> 3 cycles of StallF/D/E/M=1 and FlushW=1; ready cycle unfrozen. With RedirectE=1 throughout -> FlushD/E=0 while frozen, 1 on the ready cycle.
- TIMEOUT=4, MemReadyM held 0 -> HALT with MemErr=1 and freeze held indefinitely. Assert rst -> MemErr=0, StallCnt=0, freeze released immediately (async).
- Force 2^CNTW+5 stall cycles (CNTW=4 override) -> StallCnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: D/E/M/W register tags and memory status in, forwarding selects and
// per-stage stall/flush controls out. The slave side is the controller, the master side drives it.
interface hazard_ctrl_if #(
   parameter int CNTW = 16
);
   logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic            RegWriteM, RegWriteW, ResultSrcE0, armE, RedirectE;
   logic            MemAccessM, MemReadyM;
   logic [1:0]      ForwardAE, ForwardBE;
   logic            StallF, StallD, StallE, StallM;
   logic            FlushD, FlushE, FlushW, MemErr;
   logic [CNTW-1:0] StallCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE0, armE, RedirectE, MemAccessM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, MemErr, StallCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE0, armE, RedirectE, MemAccessM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, MemErr, StallCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational forwarding, load-use stall, redirect flush and a
// RUN/WAIT/HALT freeze FSM for slow data memory; only the FSM and stall counter are registered.
module hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

   state_t          state_q, state_d;
   logic [7:0]      wcnt_q, wcnt_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic            memwait, lduse, freeze;

   // RISC-V x0 is hardwired zero and must never be forwarded; ARM R0 is a real register.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic wr_m, input logic [4:0] rd_w,
                                          input logic wr_w, input logic arm);
      logic live;
      live = arm || (rs != 5'd0);
      if (wr_m && (rd_m == rs) && live)      return 2'b10;
      else if (wr_w && (rd_w == rs) && live) return 2'b01;
      else                                   return 2'b00;
   endfunction

   always_comb begin
      hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, hz.armE);
      hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, hz.armE);
   end

   always_comb begin
      memwait = hz.MemAccessM && !hz.MemReadyM;
      lduse   = hz.ResultSrcE0 && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D))
                && (hz.armE || (hz.RdE != 5'd0));
      freeze  = (state_q == S_HALT) || memwait;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_RUN: begin
            wcnt_d = 8'd0;
            if (memwait) state_d = S_WAIT;
         end
         S_WAIT: begin
            // Ready beats timeout when both land in the same cycle.
            if (!memwait) begin
               state_d = S_RUN;
               wcnt_d  = 8'd0;
            end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
               state_d = S_HALT;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   // While frozen the redirect flush is withheld; E is held so RedirectE re-presents afterwards.
   always_comb begin
      hz.StallF = lduse;
      hz.StallD = lduse;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = hz.RedirectE;
      hz.FlushE = lduse || hz.RedirectE;
      hz.FlushW = 1'b0;
      if (freeze) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushD = 1'b0;
         hz.FlushE = 1'b0;
         hz.FlushW = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hz.StallF && (stall_cnt_q != {CNTW{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         wcnt_q      <= 8'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.MemErr   = (state_q == S_HALT);
   assign hz.StallCnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a cycle-level behavioural model.
// Inputs change 1 time unit after posedge; the model is compared at every negedge.
module tb_hazard_ctrl;
   localparam int TIMEOUT = 4;
   localparam int CNTW    = 4;
   localparam int SAT     = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b1;

   hazard_ctrl_if #(.CNTW(CNTW)) hz();

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: halted flag, run length of consecutive memory-wait cycles, stall count.
   bit m_halt;
   int m_consec;
   int m_scnt;

   function automatic int ref_fwd(input logic [4:0] rs);
      bit live;
      live = hz.armE || (rs != 0);
      if (hz.RegWriteM && hz.RdM == rs && live) return 2;
      if (hz.RegWriteW && hz.RdW == rs && live) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      bit lu, mw, frz;
      int e_sf, e_se, e_fd, e_fe, e_fw;
      if (mon_en) begin
         if (rst) begin
            m_halt   = 1'b0;
            m_consec = 0;
            m_scnt   = 0;
         end
         lu  = hz.ResultSrcE0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D) && (hz.armE || hz.RdE != 0);
         mw  = hz.MemAccessM && !hz.MemReadyM;
         frz = m_halt || mw;
         e_sf = frz ? 1 : int'(lu);
         e_se = frz ? 1 : 0;
         e_fw = frz ? 1 : 0;
         e_fd = frz ? 0 : int'(hz.RedirectE);
         e_fe = frz ? 0 : int'(lu || hz.RedirectE);
         chk("mdl_fwdA",   hz.ForwardAE, ref_fwd(hz.Rs1E));
         chk("mdl_fwdB",   hz.ForwardBE, ref_fwd(hz.Rs2E));
         chk("mdl_stallF", hz.StallF, e_sf);
         chk("mdl_stallD", hz.StallD, e_sf);
         chk("mdl_stallE", hz.StallE, e_se);
         chk("mdl_stallM", hz.StallM, e_se);
         chk("mdl_flushD", hz.FlushD, e_fd);
         chk("mdl_flushE", hz.FlushE, e_fe);
         chk("mdl_flushW", hz.FlushW, e_fw);
         chk("mdl_memerr", hz.MemErr, int'(m_halt));
         chk("mdl_stallcnt", hz.StallCnt, m_scnt);
         if (!rst) begin
            if (!m_halt) begin
               if (mw) begin
                  m_consec++;
                  if (m_consec == TIMEOUT + 1) m_halt = 1'b1;
               end else begin
                  m_consec = 0;
               end
            end
            if (e_sf == 1 && m_scnt < SAT) m_scnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
      hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
      hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE0 = 0; hz.armE = 0;
      hz.RedirectE = 0; hz.MemAccessM = 0; hz.MemReadyM = 0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #4;
      chk("rst_stallcnt", hz.StallCnt, 0);
      chk("rst_memerr", hz.MemErr, 0);
      chk("rst_stallF", hz.StallF, 0);
      chk("rst_flushW", hz.FlushW, 0);
      tick();
      rst = 1'b0;

      // Forwarding priority and register-zero handling
      hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5;
      settle();
      chk("fwd_m_prio", hz.ForwardAE, 2);
      chk("fwd_b_none", hz.ForwardBE, 0);
      tick();
      hz.Rs1E = 0; hz.RdM = 0; hz.RdW = 0;
      settle();
      chk("fwd_rv_x0", hz.ForwardAE, 0);
      tick();
      hz.armE = 1;
      settle();
      chk("fwd_arm_r0", hz.ForwardAE, 2);
      tick();
      hz.armE = 0; hz.RegWriteM = 0; hz.Rs2E = 7; hz.RdW = 7;
      settle();
      chk("fwd_w_only", hz.ForwardBE, 1);
      tick();

      // Load-use
      idle();
      hz.ResultSrcE0 = 1; hz.RdE = 3; hz.Rs2D = 3; hz.Rs1D = 9;
      settle();
      chk("lu_stallF", hz.StallF, 1);
      chk("lu_flushE", hz.FlushE, 1);
      chk("lu_stallE", hz.StallE, 0);
      chk("lu_cnt0", hz.StallCnt, 0);
      tick();
      hz.ResultSrcE0 = 0;
      settle();
      chk("lu_off_stallF", hz.StallF, 0);
      chk("lu_off_flushE", hz.FlushE, 0);
      chk("lu_cnt1", hz.StallCnt, 1);
      tick();
      hz.ResultSrcE0 = 1; hz.RdE = 0; hz.Rs1D = 0;
      settle();
      chk("lu_rv_x0", hz.StallF, 0);
      tick();

      // Redirect alone, then with load-use
      idle();
      hz.RedirectE = 1;
      settle();
      chk("rd_flushD", hz.FlushD, 1);
      chk("rd_flushE", hz.FlushE, 1);
      chk("rd_stallF", hz.StallF, 0);
      tick();
      hz.ResultSrcE0 = 1; hz.RdE = 4; hz.Rs1D = 4;
      settle();
      chk("rd_lu_flushE", hz.FlushE, 1);
      chk("rd_lu_stallF", hz.StallF, 1);
      tick();

      // Memory wait 3 cycles with a pending redirect
      idle();
      pulse_rst();
      hz.RedirectE = 1; hz.MemAccessM = 1; hz.MemReadyM = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("mw_stallM", hz.StallM, 1);
         chk("mw_flushW", hz.FlushW, 1);
         chk("mw_flushD", hz.FlushD, 0);
         chk("mw_flushE", hz.FlushE, 0);
         tick();
      end
      hz.MemReadyM = 1;
      settle();
      chk("mw_rdy_stallF", hz.StallF, 0);
      chk("mw_rdy_flushW", hz.FlushW, 0);
      chk("mw_rdy_flushD", hz.FlushD, 1);
      chk("mw_rdy_flushE", hz.FlushE, 1);
      chk("mw_rdy_cnt", hz.StallCnt, 3);
      tick();

      // Timeout into HALT, then saturation of the stall counter
      hz.RedirectE = 0; hz.MemAccessM = 1; hz.MemReadyM = 0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("to_pre_memerr", hz.MemErr, 0);
         tick();
      end
      settle();
      chk("to_memerr", hz.MemErr, 1);
      tick();
      hz.MemAccessM = 0; hz.RedirectE = 1;
      repeat (15) tick();
      settle();
      chk("halt_stallF", hz.StallF, 1);
      chk("halt_flushW", hz.FlushW, 1);
      chk("halt_flushD", hz.FlushD, 0);
      chk("halt_memerr", hz.MemErr, 1);
      chk("halt_cnt_sat", hz.StallCnt, SAT);

      // Asynchronous reset mid-cycle releases the freeze at once
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_memerr", hz.MemErr, 0);
      chk("ar_stallcnt", hz.StallCnt, 0);
      chk("ar_stallF", hz.StallF, 0);
      chk("ar_flushW", hz.FlushW, 0);
      chk("ar_flushD", hz.FlushD, 1);
      tick();
      rst = 1'b0;

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
         hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
         hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
         hz.RdW  = 5'($urandom_range(0, 3));
         hz.RegWriteM   = 1'($urandom_range(0, 1));
         hz.RegWriteW   = 1'($urandom_range(0, 1));
         hz.ResultSrcE0 = 1'($urandom_range(0, 1));
         hz.armE        = 1'($urandom_range(0, 1));
         hz.RedirectE   = ($urandom_range(0, 3) == 0);
         hz.MemAccessM  = 1'($urandom_range(0, 1));
         hz.MemReadyM   = ($urandom_range(0, 4) < 2);
         rst            = ($urandom_range(0, 79) == 0);
      end
      tick();
      rst = 1'b0;
      tick();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
